i2c_slave_core: RTL and testbench
=================================

// Module: i2c_slave_core
// PURPOSE
//  I2C target (slave) engine: the far end of the bus driven by the I2C master. Decodes START,
//  STOP, repeated START, 7-bit address + R/W. ACKs its own address. Shifts received bytes out
//  on a valid/ready stream and shifts transmit bytes in from one. Drives SDA/SCL open-drain via
//  output enables only, and stretches SCL while no transmit byte is ready.
// PARAMETERS
//  SLAVE_ADDR      7'h50  own 7-bit bus address
//  STRETCH_EN      1      1: hold SCL low while waiting for tx byte; 0: send 8'hFF instead
// PORTS
//  i2c_core_clock_i  in   1  single clock; must be >= 8x SCL rate
//  reset_i           in   1  asynchronous, active-high reset
//  scl_i             in   1  SCL pin level (async)
//  sda_i             in   1  SDA pin level (async)
//  scl_oe_o          out  1  1 = pull SCL low (stretch)
//  sda_oe_o          out  1  1 = pull SDA low
//  rx_data_o         out  8  received data byte
//  rx_valid_o        out  1  one-cycle pulse: rx_data_o valid
//  rx_ready_i        in   1  sink can accept a byte (sampled at 8th bit)
//  tx_data_i         in   8  byte to return on read
//  tx_valid_i        in   1  tx_data_i valid
//  tx_ready_o        out  1  one-cycle pulse: tx_data_i consumed
//  busy_o            out  1  addressed: set on address ACK, cleared on STOP/START/NACK
//  rw_o              out  1  R/W bit of current transfer (1 = master reads)
//  stop_o            out  1  one-cycle pulse on any STOP detected
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; sync flops 1 (bus idle). Reset mid-transfer releases SDA/SCL
//   at once (async), with no pulse on rx_valid_o or tx_ready_o.
//  Inputs pass through 2-FF sync, then 1 history flop. rise/fall = sync vs history.
//  START = SDA fall while SCL high; STOP = SDA rise while SCL high. Both override any state,
//   release sda_oe_o/scl_oe_o and clear busy_o. START -> ADDR; STOP -> IDLE and pulse stop_o.
//  Data sampled on SCL rise; sda_oe_o changes only on SCL fall. Bit counter is 3 bits, MSB first.
//  FSM states:
//   IDLE     wait for START.
//   ADDR     shift 8 bits. Own address -> latch rw_o, -> ADDR_ACK. Otherwise -> WAIT_STOP.
//   ADDR_ACK drive SDA low for the 9th clock, set busy_o.
//            After the ACK clock: rw=0 -> RX; rw=1 -> TX_LOAD.
//   RX       shift 8 bits. On 8th rise: if rx_ready_i, latch rx_data_o and pulse rx_valid_o
//            (3 clocks after pin edge), then ACK. Else NACK (release SDA), byte dropped.
//   RX_ACK   drive ACK/NACK for the 9th clock -> RX (after ACK) or WAIT_STOP (after NACK).
//   TX_LOAD  at SCL low, if tx_valid_i: load shifter, pulse tx_ready_o, -> TX.
//            Else: STRETCH_EN=1 holds scl_oe_o=1 until tx_valid_i.
//                  STRETCH_EN=0 loads 8'hFF with no tx_ready_o.
//            Release SCL in the cycle the byte loads.
//   TX       drive bit n on SCL fall (sda_oe_o = ~bit). After 8 bits release SDA -> TX_ACK.
//   TX_ACK   sample SDA on 9th rise. 0 (ACK) -> TX_LOAD; 1 (NACK) -> WAIT_STOP, clear busy_o.
//   WAIT_STOP all released; leave only on START or STOP.
//  Simultaneous: STOP/START win over any bit event. tx_valid_i at the load point is consumed
//   only once. rx_ready_i is sampled only on the 8th-bit rise.
//  Never drives SDA while SCL is high, except to hold a level set on the prior fall.
// STRUCTURE
//  Shared include i2c_defines.vh: FSM state encodings (4-bit), ACK=1'b0/NACK=1'b1 constants.
//  Sub-module i2c_slave_line_sync: 2-FF sync + history flops, outputs scl/sda levels,
//   scl_rise/scl_fall, start_det/stop_det pulses. Everything else lives in the FSM,
//   shifter and counter here.
// TESTING
//  1 Write 0xA0 then 0x3C, 0x81, STOP; rx_ready_i=1
//    -> ACK on all 3; rx_valid_o x2 with 0x3C, 0x81; stop_o pulse; busy_o 1 -> 0.
//  2 Address 0x52 (0x29 W)
//    -> NACK, sda_oe_o stays 0, no rx_valid_o; next START to 0x50 acked normally.
//  3 Read 0xA1, tx_valid_i low 40 clocks, then 0x5A
//    -> scl_oe_o=1 for the wait, then one tx_ready_o pulse.
//    Master sees 0x5A; master NACK -> WAIT_STOP.
//  4 Write to 0x50 with rx_ready_i=0 at 8th bit -> data NACK, no rx_valid_o, WAIT_STOP.
//  5 Write 0xA0, 0x11, repeated START, 0xA1, read 0x77
//    -> rw_o 0 -> 1, busy_o re-asserted, byte 0x77 sent.
//  6 reset_i pulsed during 4th data bit with sda_oe_o=1
//    -> sda_oe_o/scl_oe_o drop same cycle; FSM IDLE; next transfer clean.

Source files
------------

// File: rtl/i2c_slave_core_pkg.sv
// i2c_slave_core_pkg
//   Shared definitions for the I2C target engine: FSM state encodings (4-bit)
//   and the bus-level ACK/NACK values.
package i2c_slave_core_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_RX        = 4'd3,
        ST_RX_ACK    = 4'd4,
        ST_TX_LOAD   = 4'd5,
        ST_TX        = 4'd6,
        ST_TX_ACK    = 4'd7,
        ST_WAIT_STOP = 4'd8
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_core_if.sv
// i2c_slave_core_if
//   Bus pins (SCL/SDA levels in, open-drain enables out) plus the rx/tx byte
//   streams and status of the I2C target.
//   slave  : view taken by i2c_slave_core
//   master : view taken by whatever drives the pins and streams (bench/system)
interface i2c_slave_core_if;
    logic       scl_i;
    logic       sda_i;
    logic       scl_oe_o;
    logic       sda_oe_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       busy_o;
    logic       rw_o;
    logic       stop_o;

    modport slave (
        input  scl_i, sda_i, rx_ready_i, tx_data_i, tx_valid_i,
        output scl_oe_o, sda_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
               busy_o, rw_o, stop_o
    );

    modport master (
        output scl_i, sda_i, rx_ready_i, tx_data_i, tx_valid_i,
        input  scl_oe_o, sda_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
               busy_o, rw_o, stop_o
    );
endinterface

// File: rtl/i2c_slave_line_sync.sv
// i2c_slave_line_sync
//   2-FF synchroniser plus one history flop per pin. Edge/condition pulses are
//   derived from synced vs history, so everything is one clock wide.
//   i_clk, i_rst       : clock, async active-high reset (flops reset to 1 = idle bus)
//   i_scl, i_sda       : raw pin levels
//   o_scl, o_sda       : synchronised levels
//   o_scl_rise/fall    : SCL edge pulses
//   o_start, o_stop    : SDA fall / rise while SCL stays high
module i2c_slave_line_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);
    logic [1:0] r_meta;   // {scl, sda}
    logic [1:0] r_sync;
    logic [1:0] r_hist;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 2'b11;
            r_sync <= 2'b11;
            r_hist <= 2'b11;
        end else begin
            r_meta <= {i_scl, i_sda};
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_scl      = r_sync[1];
    assign o_sda      = r_sync[0];
    assign o_scl_rise =  r_sync[1] & ~r_hist[1];
    assign o_scl_fall = ~r_sync[1] &  r_hist[1];
    // SCL must be high both before and after the SDA edge to count as START/STOP
    assign o_start    = r_sync[1] & r_hist[1] & ~r_sync[0] &  r_hist[0];
    assign o_stop     = r_sync[1] & r_hist[1] &  r_sync[0] & ~r_hist[0];
endmodule

// File: rtl/i2c_slave_core.sv
// i2c_slave_core
//   I2C target engine: decodes START/STOP/repeated START and a 7-bit address,
//   ACKs its own address, streams received bytes out and transmit bytes in,
//   and stretches SCL while waiting for a transmit byte (STRETCH_EN=1).
//   i2c_core_clock_i : clock, >= 8x SCL rate
//   reset_i          : async active-high reset
//   bus              : pins, rx/tx streams and status (i2c_slave_core_if.slave)
module i2c_slave_core
    import i2c_slave_core_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter bit         STRETCH_EN = 1'b1
) (
    input  logic             i2c_core_clock_i,
    input  logic             reset_i,
    i2c_slave_core_if.slave  bus
);
    logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop;

    i2c_slave_line_sync u_sync (
        .i_clk      (i2c_core_clock_i),
        .i_rst      (reset_i),
        .i_scl      (bus.scl_i),
        .i_sda      (bus.sda_i),
        .o_scl      (w_scl),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    state_t     r_state, w_state_nx;
    logic [7:0] r_shift, w_shift_nx;
    logic [2:0] r_bitcnt, w_bitcnt_nx;
    logic [7:0] r_rx_data, w_rx_data_nx;
    logic       r_sda_oe, w_sda_oe_nx;
    logic       r_scl_oe, w_scl_oe_nx;
    logic       r_busy, w_busy_nx;
    logic       r_rw, w_rw_nx;
    logic       r_rx_valid, w_rx_valid_nx;
    logic       r_tx_ready, w_tx_ready_nx;
    logic       r_stop, w_stop_nx;
    logic       r_phase, w_phase_nx;   // ACK states: 0 = before 9th clock, 1 = during it
    logic       r_ack, w_ack_nx;       // ACK/NACK decided for the current rx byte
    logic [7:0] w_byte;

    // Byte as it stands once the bit sampled on this rise is shifted in
    assign w_byte = {r_shift[6:0], w_sda};

    always_ff @(posedge i2c_core_clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_shift    <= 8'h00;
            r_bitcnt   <= 3'd0;
            r_rx_data  <= 8'h00;
            r_sda_oe   <= 1'b0;
            r_scl_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_stop     <= 1'b0;
            r_phase    <= 1'b0;
            r_ack      <= ACK;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_bitcnt   <= w_bitcnt_nx;
            r_rx_data  <= w_rx_data_nx;
            r_sda_oe   <= w_sda_oe_nx;
            r_scl_oe   <= w_scl_oe_nx;
            r_busy     <= w_busy_nx;
            r_rw       <= w_rw_nx;
            r_rx_valid <= w_rx_valid_nx;
            r_tx_ready <= w_tx_ready_nx;
            r_stop     <= w_stop_nx;
            r_phase    <= w_phase_nx;
            r_ack      <= w_ack_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_bitcnt_nx   = r_bitcnt;
        w_rx_data_nx  = r_rx_data;
        w_sda_oe_nx   = r_sda_oe;
        w_scl_oe_nx   = r_scl_oe;
        w_busy_nx     = r_busy;
        w_rw_nx       = r_rw;
        w_rx_valid_nx = 1'b0;
        w_tx_ready_nx = 1'b0;
        w_stop_nx     = 1'b0;
        w_phase_nx    = r_phase;
        w_ack_nx      = r_ack;

        // Bus conditions pre-empt any bit event in every state
        if (w_start) begin
            w_state_nx  = ST_ADDR;
            w_bitcnt_nx = 3'd0;
            w_sda_oe_nx = 1'b0;
            w_scl_oe_nx = 1'b0;
            w_busy_nx   = 1'b0;
            w_phase_nx  = 1'b0;
        end else if (w_stop) begin
            w_state_nx  = ST_IDLE;
            w_sda_oe_nx = 1'b0;
            w_scl_oe_nx = 1'b0;
            w_busy_nx   = 1'b0;
            w_phase_nx  = 1'b0;
            w_stop_nx   = 1'b1;
        end else begin
            case (r_state)
                ST_ADDR: if (w_rise) begin
                    w_shift_nx  = w_byte;
                    w_bitcnt_nx = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        if (w_byte[7:1] == SLAVE_ADDR) begin
                            w_rw_nx    = w_byte[0];
                            w_state_nx = ST_ADDR_ACK;
                        end else begin
                            w_state_nx = ST_WAIT_STOP;
                        end
                    end
                end
                // First fall opens the 9th clock (drive ACK), second fall closes it
                ST_ADDR_ACK: if (w_fall) begin
                    if (!r_phase) begin
                        w_sda_oe_nx = 1'b1;
                        w_busy_nx   = 1'b1;
                        w_phase_nx  = 1'b1;
                    end else begin
                        w_sda_oe_nx = 1'b0;
                        w_phase_nx  = 1'b0;
                        w_bitcnt_nx = 3'd0;
                        w_state_nx  = r_rw ? ST_TX_LOAD : ST_RX;
                    end
                end
                ST_RX: if (w_rise) begin
                    w_shift_nx  = w_byte;
                    w_bitcnt_nx = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        if (bus.rx_ready_i) begin
                            w_rx_data_nx  = w_byte;
                            w_rx_valid_nx = 1'b1;
                            w_ack_nx      = ACK;
                        end else begin
                            w_ack_nx      = NACK;
                        end
                        w_state_nx = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: if (w_fall) begin
                    if (!r_phase) begin
                        w_sda_oe_nx = (r_ack == ACK);
                        w_phase_nx  = 1'b1;
                    end else begin
                        w_sda_oe_nx = 1'b0;
                        w_phase_nx  = 1'b0;
                        w_bitcnt_nx = 3'd0;
                        if (r_ack == ACK) begin
                            w_state_nx = ST_RX;
                        end else begin
                            w_state_nx = ST_WAIT_STOP;
                            w_busy_nx  = 1'b0;
                        end
                    end
                end
                // SCL is low here, so putting bit 7 on SDA immediately is safe
                ST_TX_LOAD: if (!w_scl) begin
                    if (bus.tx_valid_i) begin
                        w_shift_nx    = bus.tx_data_i;
                        w_tx_ready_nx = 1'b1;
                        w_scl_oe_nx   = 1'b0;
                        w_sda_oe_nx   = ~bus.tx_data_i[7];
                        w_bitcnt_nx   = 3'd0;
                        w_state_nx    = ST_TX;
                    end else if (STRETCH_EN) begin
                        w_scl_oe_nx   = 1'b1;
                    end else begin
                        w_shift_nx    = 8'hFF;
                        w_scl_oe_nx   = 1'b0;
                        w_sda_oe_nx   = 1'b0;
                        w_bitcnt_nx   = 3'd0;
                        w_state_nx    = ST_TX;
                    end
                end
                ST_TX: if (w_fall) begin
                    if (r_bitcnt == 3'd7) begin
                        w_sda_oe_nx = 1'b0;
                        w_state_nx  = ST_TX_ACK;
                    end else begin
                        w_shift_nx  = {r_shift[6:0], 1'b0};
                        w_bitcnt_nx = r_bitcnt + 3'd1;
                        w_sda_oe_nx = ~r_shift[6];
                    end
                end
                ST_TX_ACK: if (w_rise) begin
                    if (w_sda == ACK) begin
                        w_state_nx = ST_TX_LOAD;
                    end else begin
                        w_state_nx = ST_WAIT_STOP;
                        w_busy_nx  = 1'b0;
                    end
                end
                default: begin
                    // IDLE / WAIT_STOP: bus fully released
                    w_sda_oe_nx = 1'b0;
                    w_scl_oe_nx = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe_o   = r_sda_oe;
    assign bus.scl_oe_o   = r_scl_oe;
    assign bus.rx_data_o  = r_rx_data;
    assign bus.rx_valid_o = r_rx_valid;
    assign bus.tx_ready_o = r_tx_ready;
    assign bus.busy_o     = r_busy;
    assign bus.rw_o       = r_rw;
    assign bus.stop_o     = r_stop;
endmodule

// File: tb/tb_i2c_slave_core.sv
// tb_i2c_slave_core
//   Bit-banged I2C master with open-drain wired-AND pins against i2c_slave_core.
//   Received bytes and master-read bytes are checked against expectation queues.
module tb_i2c_slave_core;
    localparam int Q = 8;   // quarter SCL period in core clocks

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_slave_core_if ifc();
    logic m_scl_lo = 1'b0;
    logic m_sda_lo = 1'b0;
    assign ifc.scl_i = ~(m_scl_lo | ifc.scl_oe_o);
    assign ifc.sda_i = ~(m_sda_lo | ifc.sda_oe_o);

    i2c_slave_core #(.SLAVE_ADDR(7'h50), .STRETCH_EN(1'b1)) dut (
        .i2c_core_clock_i (clk),
        .reset_i          (rst),
        .bus              (ifc.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int rx_cnt = 0, txr_cnt = 0, stop_cnt = 0, sda_cyc = 0, scl_cyc = 0;
    int rx_seen = 0;
    logic [7:0] rx_log [64];
    logic [7:0] exp_rx_q [$];
    logic [7:0] exp_rd_q [$];

    always @(negedge clk) begin
        if (ifc.rx_valid_o === 1'b1) begin
            if (rx_cnt < 64) rx_log[rx_cnt] <= ifc.rx_data_o;
            rx_cnt <= rx_cnt + 1;
        end
        if (ifc.tx_ready_o === 1'b1) txr_cnt  <= txr_cnt + 1;
        if (ifc.stop_o === 1'b1)     stop_cnt <= stop_cnt + 1;
        if (ifc.sda_oe_o === 1'b1)   sda_cyc  <= sda_cyc + 1;
        if (ifc.scl_oe_o === 1'b1)   scl_cyc  <= scl_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Release SCL and wait for the line to actually go high (target may stretch)
    task automatic scl_release();
        int k;
        k = 0;
        m_scl_lo = 1'b0;
        while (ifc.scl_i !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) chk("scl_timeout", 0, 1);
    endtask

    task automatic m_start();
        m_sda_lo = 1'b0; tick(Q);
        scl_release();   tick(Q);
        m_sda_lo = 1'b1; tick(Q);
        m_scl_lo = 1'b1; tick(Q);
    endtask

    task automatic m_stop();
        m_sda_lo = 1'b1; tick(Q);
        scl_release();   tick(Q);
        m_sda_lo = 1'b0; tick(2*Q);
    endtask

    task automatic wr_bit(input bit b);
        m_sda_lo = ~b;   tick(Q);
        scl_release();   tick(2*Q);
        m_scl_lo = 1'b1; tick(Q);
    endtask

    task automatic rd_bit(output bit b);
        m_sda_lo = 1'b0; tick(Q);
        scl_release();   tick(Q);
        b = ifc.sda_i;   tick(Q);
        m_scl_lo = 1'b1; tick(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output bit ack);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(ack);
    endtask

    task automatic rd_byte(output logic [7:0] d, input bit nack);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(nack);
    endtask

    // Offer one tx byte; optionally first wait for the stretch, then 40 clocks
    task automatic tx_feed(input logic [7:0] d, input bit after_stretch, input bit push);
        int k;
        k = 0;
        if (after_stretch) begin
            while (ifc.scl_oe_o !== 1'b1 && k < 4000) begin @(negedge clk); k++; end
            if (k >= 4000) chk("stretch_timeout", 0, 1);
            tick(40);
            k = 0;
        end
        ifc.tx_data_i  = d;
        ifc.tx_valid_i = 1'b1;
        if (push) exp_rd_q.push_back(d);
        while (ifc.tx_ready_o !== 1'b1 && k < 4000) begin @(negedge clk); k++; end
        if (k >= 4000) chk("tx_ready_timeout", 0, 1);
        ifc.tx_valid_i = 1'b0;
    endtask

    task automatic drain_rx();
        while (rx_seen < rx_cnt) begin
            if (exp_rx_q.size() == 0) chk("rx_unexpected", 32'(rx_log[rx_seen]), 32'h100);
            else                      chk("rx_data", 32'(rx_log[rx_seen]), 32'(exp_rx_q.pop_front()));
            rx_seen++;
        end
    endtask

    task automatic check_rd(input logic [7:0] d);
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 32'(d), 32'h100);
        else                      chk("rd_data", 32'(d), 32'(exp_rd_q.pop_front()));
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within 80000 cycles");
        $fatal(1, "watchdog");
    end

    logic [7:0] d;
    bit ack, b0, b1, b2;
    int r0, t0, s0, c0;

    initial begin
        ifc.rx_ready_i = 1'b1;
        ifc.tx_valid_i = 1'b0;
        ifc.tx_data_i  = 8'h00;
        rst = 1'b1;
        tick(4);
        chk("rst_outs", 32'({ifc.sda_oe_o, ifc.scl_oe_o, ifc.rx_valid_o, ifc.tx_ready_o,
                             ifc.busy_o, ifc.rw_o, ifc.stop_o}), 0);
        chk("rst_rxdata", 32'(ifc.rx_data_o), 0);
        rst = 1'b0;
        tick(4);

        // 1: write two bytes, STOP
        r0 = rx_cnt;
        m_start();
        wr_byte(8'hA0, ack); chk("t1_addr_ack", 32'(ack), 0);
        chk("t1_busy", 32'(ifc.busy_o), 1);
        chk("t1_rw", 32'(ifc.rw_o), 0);
        exp_rx_q.push_back(8'h3C);
        wr_byte(8'h3C, ack); chk("t1_d0_ack", 32'(ack), 0);
        exp_rx_q.push_back(8'h81);
        wr_byte(8'h81, ack); chk("t1_d1_ack", 32'(ack), 0);
        drain_rx();
        chk("t1_rx_count", rx_cnt - r0, 2);
        s0 = stop_cnt;
        m_stop();
        chk("t1_stop_pulse", stop_cnt - s0, 1);
        chk("t1_busy_off", 32'(ifc.busy_o), 0);

        // 2: foreign address, then own address
        r0 = rx_cnt; c0 = sda_cyc;
        m_start();
        wr_byte(8'h52, ack); chk("t2_addr_nack", 32'(ack), 1);
        m_stop();
        chk("t2_sda_quiet", sda_cyc - c0, 0);
        chk("t2_no_rx", rx_cnt - r0, 0);
        chk("t2_busy", 32'(ifc.busy_o), 0);
        m_start();
        wr_byte(8'hA0, ack); chk("t2_own_ack", 32'(ack), 0);
        m_stop();

        // 3: read with a 40-clock stall, master NACK
        t0 = txr_cnt; c0 = scl_cyc;
        m_start();
        wr_byte(8'hA1, ack); chk("t3_addr_ack", 32'(ack), 0);
        chk("t3_rw", 32'(ifc.rw_o), 1);
        fork
            tx_feed(8'h5A, 1'b1, 1'b1);
            rd_byte(d, 1'b1);
        join
        check_rd(d);
        chk("t3_stretch_len", 32'((scl_cyc - c0) >= 40 && (scl_cyc - c0) <= 50), 1);
        chk("t3_tx_ready_cnt", txr_cnt - t0, 1);
        chk("t3_scl_released", 32'(ifc.scl_oe_o), 0);
        chk("t3_busy_off", 32'(ifc.busy_o), 0);
        m_stop();

        // 4: sink not ready -> data NACK, then WAIT_STOP ignores further bytes
        r0 = rx_cnt;
        m_start();
        wr_byte(8'hA0, ack); chk("t4_addr_ack", 32'(ack), 0);
        ifc.rx_ready_i = 1'b0;
        wr_byte(8'h55, ack); chk("t4_data_nack", 32'(ack), 1);
        chk("t4_busy_off", 32'(ifc.busy_o), 0);
        ifc.rx_ready_i = 1'b1;
        wr_byte(8'h66, ack); chk("t4_wait_stop_nack", 32'(ack), 1);
        chk("t4_no_rx", rx_cnt - r0, 0);
        m_stop();

        // 5: write, repeated START, read
        m_start();
        wr_byte(8'hA0, ack); chk("t5_waddr_ack", 32'(ack), 0);
        exp_rx_q.push_back(8'h11);
        wr_byte(8'h11, ack); chk("t5_wdata_ack", 32'(ack), 0);
        drain_rx();
        chk("t5_rw_w", 32'(ifc.rw_o), 0);
        m_start();
        chk("t5_rs_busy_clr", 32'(ifc.busy_o), 0);
        wr_byte(8'hA1, ack); chk("t5_raddr_ack", 32'(ack), 0);
        chk("t5_rw_r", 32'(ifc.rw_o), 1);
        chk("t5_busy_again", 32'(ifc.busy_o), 1);
        t0 = txr_cnt;
        fork
            tx_feed(8'h77, 1'b0, 1'b1);
            rd_byte(d, 1'b1);
        join
        check_rd(d);
        chk("t5_tx_ready_cnt", txr_cnt - t0, 1);
        m_stop();

        // 6: reset while driving the 4th bit of a read (all-zero byte)
        m_start();
        wr_byte(8'hA1, ack); chk("t6_addr_ack", 32'(ack), 0);
        fork
            tx_feed(8'h00, 1'b0, 1'b0);
            begin rd_bit(b0); rd_bit(b1); rd_bit(b2); end
        join
        chk("t6_first_bits", 32'({b0, b1, b2}), 0);
        tick(2);
        chk("t6_sda_driven", 32'(ifc.sda_oe_o), 1);
        r0 = rx_cnt; t0 = txr_cnt;
        rst = 1'b1;
        #1;
        chk("t6_rst_sda", 32'(ifc.sda_oe_o), 0);
        chk("t6_rst_scl", 32'(ifc.scl_oe_o), 0);
        tick(3);
        rst = 1'b0;
        tick(2);
        chk("t6_busy", 32'(ifc.busy_o), 0);
        chk("t6_no_pulses", (rx_cnt - r0) + (txr_cnt - t0), 0);
        m_start();
        wr_byte(8'hA0, ack); chk("t6_clean_ack", 32'(ack), 0);
        exp_rx_q.push_back(8'h99);
        wr_byte(8'h99, ack); chk("t6_clean_data_ack", 32'(ack), 0);
        drain_rx();
        m_stop();
        chk("t6_end_busy", 32'(ifc.busy_o), 0);

        chk("rx_queue_left", exp_rx_q.size(), 0);
        chk("rd_queue_left", exp_rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
